down_counter_timer: RTL and testbench

Loadable, prescaled down-counter that starts from a programmed value and counts toward zero, issuing a one-cycle terminal-count pulse. It is the counterpart of the free-running up-counter in the VGA design. Pixel and line sequencing logic uses it to time fixed-length intervals such as porch, sync, and blanking widths, in either one-shot or auto-reload mode.

---
 rtl/down_counter_timer.sv | 116 +++++++++++
 tb/tb_down_counter_timer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/down_counter_timer.sv
`default_nettype none
// ============================================================================
//  Module      : down_counter_timer
//  Description : Loadable, prescaled down-counter. Counts from a programmed
//                value toward zero and emits a one-cycle terminal-count
//                pulse, in one-shot or auto-reload mode. Used to time fixed
//                intervals such as porch, sync and blanking widths.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   rising-edge clock
//    rst_n      in   asynchronous, active-low reset
//    load       in   capture load_value into count and reload register
//    load_value in   [BIT_WIDTH]      start / reload value
//    enable     in   low freezes count and prescaler
//    periodic   in   1 = auto-reload at terminal count, 0 = one-shot
//    prescale   in   [PRESCALE_WIDTH] tick every prescale+1 enabled cycles
//    q          out  [BIT_WIDTH]      current count
//    tc         out  registered terminal-count pulse, one cycle wide
//    busy       out  high while running
// ============================================================================
module down_counter_timer #(
    parameter int BIT_WIDTH      = 4,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic [BIT_WIDTH-1:0]      load_value,
    input  logic                      enable,
    input  logic                      periodic,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic [BIT_WIDTH-1:0]      q,
    output logic                      tc,
    output logic                      busy
);

    localparam logic [BIT_WIDTH-1:0]      c_count_one = BIT_WIDTH'(1);
    localparam logic [PRESCALE_WIDTH-1:0] c_psc_one   = PRESCALE_WIDTH'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [BIT_WIDTH-1:0]      r_count;
    logic [BIT_WIDTH-1:0]      w_count_nxt;
    logic [BIT_WIDTH-1:0]      r_reload;
    logic [BIT_WIDTH-1:0]      w_reload_nxt;
    logic [PRESCALE_WIDTH-1:0] r_presc;
    logic [PRESCALE_WIDTH-1:0] w_presc_nxt;
    logic                      r_tc;
    logic                      w_tc_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_reload <= '0;
            r_presc  <= '0;
            r_tc     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_reload <= w_reload_nxt;
            r_presc  <= w_presc_nxt;
            r_tc     <= w_tc_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_reload_nxt = r_reload;
        w_presc_nxt  = r_presc;
        w_tc_nxt     = 1'b0;

        if (load) begin
            // Load overrides everything, including a coincident terminal tick.
            w_count_nxt  = load_value;
            w_reload_nxt = load_value;
            w_presc_nxt  = '0;
            w_state_nxt  = (load_value != '0) ? ST_RUN : ST_IDLE;
        end else if (r_state == ST_RUN && enable) begin
            // >= rather than == so that lowering prescale mid-interval ticks
            // on the next cycle instead of running the prescaler to wrap.
            if (r_presc >= prescale) begin
                w_presc_nxt = '0;
                if (r_count > c_count_one) begin
                    w_count_nxt = r_count - c_count_one;
                end else if (r_count == c_count_one) begin
                    w_tc_nxt = 1'b1;
                    if (periodic) begin
                        w_count_nxt = r_reload;
                    end else begin
                        w_count_nxt = '0;
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    // Count of zero while running is unreachable; park safely.
                    w_state_nxt = ST_IDLE;
                end
            end else begin
                w_presc_nxt = r_presc + c_psc_one;
            end
        end
    end

    assign q    = r_count;
    assign tc   = r_tc;
    assign busy = (r_state == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_down_counter_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_down_counter_timer
//  Description : Self-checking bench for down_counter_timer. The driver
//                applies directed vectors and queues the hand-computed
//                post-edge expectation; a monitor pops and compares after
//                each rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_down_counter_timer;

    logic       clk;
    logic       rst_n;
    logic       load;
    logic [3:0] load_value;
    logic       enable;
    logic       periodic;
    logic [7:0] prescale;
    logic [3:0] q;
    logic       tc;
    logic       busy;

    typedef struct {
        logic [3:0] q;
        logic       tc;
        logic       busy;
        string      nm;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    down_counter_timer #(
        .BIT_WIDTH     (4),
        .PRESCALE_WIDTH(8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_value(load_value),
        .enable    (enable),
        .periodic  (periodic),
        .prescale  (prescale),
        .q         (q),
        .tc        (tc),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [3:0] eq, input logic etc, input logic ebusy);
        n_checks++;
        if ({q, tc, busy} !== {eq, etc, ebusy}) begin
            n_fail++;
            $display("FAIL %s: got q=%0d tc=%0b busy=%0b, expected q=%0d tc=%0b busy=%0b",
                     nm, q, tc, busy, eq, etc, ebusy);
        end
    endtask

    // Monitor: compare the outputs settled after each edge.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.nm, e.q, e.tc, e.busy);
        end
    end

    // Driver: apply inputs for the next edge and queue what must follow it.
    task automatic step(input logic ld, input logic [3:0] lv, input logic en,
                        input logic per, input logic [7:0] psc,
                        input logic [3:0] eq, input logic etc, input logic ebusy,
                        input string nm);
        exp_t e;
        load       = ld;
        load_value = lv;
        enable     = en;
        periodic   = per;
        prescale   = psc;
        e.q = eq; e.tc = etc; e.busy = ebusy; e.nm = nm;
        sb.push_back(e);
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; load = 1'b0; load_value = '0; enable = 1'b0;
        periodic = 1'b0; prescale = '0;
        #3;
        chk("reset_state", 4'd0, 1'b0, 1'b0);
        #9 rst_n = 1'b1;
        @(posedge clk);
        #2;

        // Reset mid-count
        step(1, 9, 1, 0, 0, 4'd9, 0, 1, "rst_load9");
        step(0, 0, 1, 0, 0, 4'd8, 0, 1, "rst_run1");
        step(0, 0, 1, 0, 0, 4'd7, 0, 1, "rst_run2");
        step(0, 0, 1, 0, 0, 4'd6, 0, 1, "rst_run3");
        rst_n = 1'b0;
        #1;
        chk("async_reset", 4'd0, 1'b0, 1'b0);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) step(0, 0, 1, 0, 0, 4'd0, 0, 0, "post_reset_idle");

        // One-shot
        step(1, 3, 1, 0, 0, 4'd3, 0, 1, "os_load3");
        step(0, 0, 1, 0, 0, 4'd2, 0, 1, "os_q2");
        step(0, 0, 1, 0, 0, 4'd1, 0, 1, "os_q1");
        step(0, 0, 1, 0, 0, 4'd0, 1, 0, "os_tc");
        step(0, 0, 1, 0, 0, 4'd0, 0, 0, "os_hold0_a");
        step(0, 0, 1, 0, 0, 4'd0, 0, 0, "os_hold0_b");

        // Periodic with prescaler: L=2, P=2 -> period 6
        step(1, 2, 1, 1, 2, 4'd2, 0, 1, "per_load2");
        for (int k = 1; k <= 18; k++) begin
            step(0, 0, 1, 1, 2,
                 ((k % 6) == 0 || (k % 6) < 3) ? 4'd2 : 4'd1,
                 ((k % 6) == 0), 1, "per_seq");
        end

        // Enable gating: tc 5 cycles later than ungated
        step(1, 4, 1, 0, 0, 4'd4, 0, 1, "gate_load4");
        step(0, 0, 1, 0, 0, 4'd3, 0, 1, "gate_q3");
        for (int k = 0; k < 5; k++) step(0, 0, 0, 0, 0, 4'd3, 0, 1, "gate_hold3");
        step(0, 0, 1, 0, 0, 4'd2, 0, 1, "gate_q2");
        step(0, 0, 1, 0, 0, 4'd1, 0, 1, "gate_q1");
        step(0, 0, 1, 0, 0, 4'd0, 1, 0, "gate_tc");
        step(0, 0, 1, 0, 0, 4'd0, 0, 0, "gate_after");

        // Load collides with terminal tick, then zero load
        step(1, 2, 1, 1, 0, 4'd2, 0, 1, "col_load2");
        step(0, 0, 1, 1, 0, 4'd1, 0, 1, "col_q1");
        step(1, 5, 1, 1, 0, 4'd5, 0, 1, "col_load5_on_tc");
        step(0, 0, 1, 1, 0, 4'd4, 0, 1, "col_q4");
        step(1, 0, 1, 1, 0, 4'd0, 0, 0, "zero_load");
        step(0, 0, 1, 1, 0, 4'd0, 0, 0, "zero_idle");

        // Max value: 15 ticks, no wrap
        step(1, 15, 1, 0, 0, 4'd15, 0, 1, "max_load15");
        for (int k = 1; k <= 14; k++) step(0, 0, 1, 0, 0, 4'(15 - k), 0, 1, "max_count");
        step(0, 0, 1, 0, 0, 4'd0, 1, 0, "max_tc");
        step(0, 0, 1, 0, 0, 4'd0, 0, 0, "max_nowrap_a");
        step(0, 0, 1, 0, 0, 4'd0, 0, 0, "max_nowrap_b");

        // Prescale decrease 7 -> 1 with prescaler at 5
        step(1, 3, 1, 0, 7, 4'd3, 0, 1, "psc_load3");
        for (int k = 1; k <= 5; k++) step(0, 0, 1, 0, 7, 4'd3, 0, 1, "psc_wait");
        step(0, 0, 1, 0, 1, 4'd2, 0, 1, "psc_drop_tick");
        step(0, 0, 1, 0, 1, 4'd2, 0, 1, "psc_p1_a");
        step(0, 0, 1, 0, 1, 4'd1, 0, 1, "psc_tick2");
        step(0, 0, 1, 0, 1, 4'd1, 0, 1, "psc_p1_b");
        step(0, 0, 1, 0, 1, 4'd0, 1, 0, "psc_tc");
        step(0, 0, 1, 0, 1, 4'd0, 0, 0, "psc_after");

        #5;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
